pico_sequencer: RTL and testbench

Four-phase instruction sequencer for the picoMips core. It replaces the free-running program counter and its phase-bit decode with an explicit state machine. The state machine drives the program-memory address, the instruction fetch enable, the register-file read/write strobes and the accumulator write enable. It also owns the SW8 synchroniser/debouncer that resolves HEI (hold-while-equal) waits, so the datapath only sees clean, single-cycle strobes.

---
 rtl/pico_pkg.sv | 31 +++
 rtl/sw_debounce.sv | 46 ++++
 rtl/pico_sequencer.sv | 101 ++++++++++
 tb/tb_pico_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pico_pkg.sv
// Shared definitions for the picoMips sequencer: FSM states, Func bit positions,
// phase encodings and the instruction opcodes.
package pico_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StWait,
    StWrite,
    StIdle
  } state_e;

  localparam int unsigned FUNC_HEI  = 5;
  localparam int unsigned FUNC_REGW = 4;

  localparam logic [1:0] PHASE_FETCH  = 2'd0;
  localparam logic [1:0] PHASE_DECODE = 2'd1;
  localparam logic [1:0] PHASE_EXEC   = 2'd2;
  localparam logic [1:0] PHASE_WRITE  = 2'd3;

  // Func[5] selects HEI, Func[4] selects a register-file write.
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_MULI = 6'b000100;
  localparam logic [5:0] OP_MOV  = 6'b010000;
  localparam logic [5:0] OP_LDSW = 6'b010001;
  localparam logic [5:0] OP_HEI  = 6'b100000;

endpackage

// File: rtl/sw_debounce.sv
// SW8 two-flop synchroniser and debouncer; the output only changes after the
// synchronised input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic nReset,
  input  logic sw_raw,
  output logic sw_db
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

  logic            s1_q, s2_q;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= sw_raw;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign sw_db = db_q;

endmodule

// File: rtl/pico_sequencer.sv
// Four-phase picoMips instruction sequencer: FSM, program address register and
// strobe decode, with HEI waits resolved against the debounced SW8.
module pico_sequencer
  import pico_pkg::*;
#(
  parameter int unsigned PC_WIDTH        = 5,
  parameter int unsigned PROG_LAST       = 23,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic [5:0]          Func,
  input  logic                HeiArg,
  input  logic                Sw8,
  input  logic                Hold,
  output logic [PC_WIDTH-1:0] InstrAddr,
  output logic [1:0]          Phase,
  output logic                FetchEn,
  output logic                RegRe,
  output logic                AccWe,
  output logic                RegWe,
  output logic                Waiting,
  output logic                Idle
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                sw8_db;
  logic                hei, regw, sw_match;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .Clock (Clock),
    .nReset(nReset),
    .sw_raw(Sw8),
    .sw_db (sw8_db)
  );

  assign hei      = Func[FUNC_HEI];
  assign regw     = Func[FUNC_REGW];
  assign sw_match = (sw8_db == HeiArg);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    Phase   = PHASE_FETCH;
    FetchEn = 1'b0;
    RegRe   = 1'b0;
    AccWe   = 1'b0;
    RegWe   = 1'b0;
    Waiting = 1'b0;
    Idle    = 1'b0;
    unique case (state_q)
      StFetch: begin
        FetchEn = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        Phase   = PHASE_DECODE;
        RegRe   = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        Phase   = PHASE_EXEC;
        AccWe   = !hei && !regw;
        state_d = (hei && sw_match) ? StWait : StWrite;
      end
      StWait: begin
        Phase   = PHASE_WRITE;
        Waiting = 1'b1;
        if (!sw_match) state_d = StWrite;
      end
      StWrite: begin
        Phase   = PHASE_WRITE;
        RegWe   = regw && !hei;
        addr_d  = (addr_q == PC_WIDTH'(PROG_LAST)) ? '0 : addr_q + PC_WIDTH'(1);
        // Hold only takes effect at an instruction boundary.
        state_d = Hold ? StIdle : StFetch;
      end
      StIdle: begin
        Idle = 1'b1;
        if (!Hold) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= StFetch;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign InstrAddr = addr_q;

endmodule

// File: tb/tb_pico_sequencer.sv
// Bench for pico_sequencer: instruction-level reference model checked every cycle,
// directed timing checks, then randomized programs, switch activity and Hold.
module tb_pico_sequencer;
  import pico_pkg::*;

  localparam int D    = 4;
  localparam int LAST = 23;
  // Model step labels (where the model is within an instruction).
  localparam int MF = 0, MD = 1, ME = 2, MWR = 3, MW = 4, MI = 5;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic [5:0] Func = '0;
  logic       HeiArg = 1'b0, Sw8 = 1'b0, Hold = 1'b0;
  logic [4:0] InstrAddr;
  logic [1:0] Phase;
  logic       FetchEn, RegRe, AccWe, RegWe, Waiting, Idle;

  int         tests = 0;
  int         fails = 0;

  logic [5:0] imem[LAST+1];
  logic       iarg[LAST+1];

  int         m_step, m_addr;
  logic [5:0] m_func;
  logic       m_arg, m_db;
  logic       hist[$];

  pico_sequencer #(
    .PC_WIDTH(5),
    .PROG_LAST(LAST),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .Func     (Func),
    .HeiArg   (HeiArg),
    .Sw8      (Sw8),
    .Hold     (Hold),
    .InstrAddr(InstrAddr),
    .Phase    (Phase),
    .FetchEn  (FetchEn),
    .RegRe    (RegRe),
    .AccWe    (AccWe),
    .RegWe    (RegWe),
    .Waiting  (Waiting),
    .Idle     (Idle)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_step = MF;
    m_addr = 0;
    m_db   = 1'b0;
    hist.delete();
    repeat (D + 2) hist.push_back(1'b0);
  endtask

  // One clock edge of the reference model, using the inputs held before the edge.
  task automatic model_step();
    bit all_differ;
    if (!nReset) begin
      model_reset();
      return;
    end
    hist.push_back(Sw8);
    case (m_step)
      MF: begin
        m_step = MD;
        m_func = imem[m_addr];
        m_arg  = iarg[m_addr];
      end
      MD: m_step = ME;
      ME, MW: m_step = (m_func[5] && m_db == m_arg) ? MW : MWR;
      MWR: begin
        m_addr = (m_addr == LAST) ? 0 : m_addr + 1;
        m_step = Hold ? MI : MF;
      end
      default: m_step = Hold ? MI : MF;
    endcase
    // Debounced switch flips once the last D synchronised samples all disagree with it;
    // the synchroniser delays raw samples by two edges.
    all_differ = 1'b1;
    for (int i = 1; i <= D; i++) if (hist[i] == m_db) all_differ = 1'b0;
    if (all_differ) m_db = ~m_db;
    void'(hist.pop_front());
  endtask

  task automatic cyc();
    @(posedge Clock);
    model_step();
    #1;
    if (m_step == MD) begin
      Func   = m_func;
      HeiArg = m_arg;
    end
  endtask

  always @(negedge Clock) begin
    check("FetchEn", 32'(FetchEn), 32'(m_step == MF));
    check("RegRe", 32'(RegRe), 32'(m_step == MD));
    check("AccWe", 32'(AccWe), 32'(m_step == ME && !m_func[5] && !m_func[4]));
    check("RegWe", 32'(RegWe), 32'(m_step == MWR && !m_func[5] && m_func[4]));
    check("Waiting", 32'(Waiting), 32'(m_step == MW));
    check("Idle", 32'(Idle), 32'(m_step == MI));
    check("InstrAddr", 32'(InstrAddr), 32'(m_addr));
    if (m_step != MI)
      check("Phase", 32'(Phase), (m_step == MW) ? 32'd3 : 32'(m_step));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i <= LAST; i++) begin
      imem[i] = {1'b0, 5'($urandom)};
      iarg[i] = 1'b0;
    end
    imem[0] = OP_HEI;  iarg[0] = 1'b0;
    imem[1] = OP_MOV;
    imem[2] = OP_ADD;
    imem[3] = OP_HEI;  iarg[3] = 1'b1;
    m_func = '0;
    m_arg  = 1'b0;
    model_reset();

    // Reset values, held across edges.
    repeat (2) @(posedge Clock);
    #3;
    check("rst_fetchen", 32'(FetchEn), 32'd1);
    check("rst_addr", 32'(InstrAddr), 32'd0);
    check("rst_phase", 32'(Phase), 32'd0);
    check("rst_strobes", 32'({RegRe, AccWe, RegWe, Waiting, Idle}), 32'd0);
    nReset = 1'b1;

    // HEI with HeiArg=0 and SW8 low blocks; raising SW8 ends the wait D+3 edges later.
    repeat (3) cyc();
    check("hei_waiting", 32'(Waiting), 32'd1);
    repeat (5) cyc();
    check("hei_still_waiting", 32'(Waiting), 32'd1);
    Sw8 = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (Waiting && n < 20);
    check("hei_exit_edges", 32'(n), 32'd7);
    check("hei_exit_phase", 32'(Phase), 32'd3);
    cyc();
    check("hei_next_addr", 32'(InstrAddr), 32'd1);

    // Register-write instruction then accumulator instruction.
    repeat (2) cyc();
    check("regw_no_acc", 32'(AccWe), 32'd0);
    cyc();
    check("regw_strobe", 32'(RegWe), 32'd1);
    repeat (3) cyc();
    check("acc_strobe", 32'(AccWe), 32'd1);
    cyc();
    check("acc_no_regw", 32'(RegWe), 32'd0);

    // 3-cycle SW8 glitch during a WAIT must not release it.
    repeat (4) cyc();
    check("glitch_enter", 32'(Waiting), 32'd1);
    Sw8 = 1'b0;
    repeat (3) cyc();
    Sw8 = 1'b1;
    repeat (10) cyc();
    check("glitch_wait", 32'(Waiting), 32'd1);
    Sw8 = 1'b0;
    n = 0;
    while (Waiting && n < 20) begin
      cyc();
      n++;
    end
    check("glitch_release", 32'(Waiting), 32'd0);
    cyc();

    // Wrap from PROG_LAST, with Hold raised during EXEC.
    n = 0;
    while (!(m_addr == LAST && m_step == ME) && n < 200) begin
      cyc();
      n++;
    end
    Hold = 1'b1;
    repeat (2) cyc();
    check("wrap_idle", 32'(Idle), 32'd1);
    check("wrap_addr", 32'(InstrAddr), 32'd0);
    repeat (2) cyc();
    check("hold_idle", 32'(Idle), 32'd1);
    Hold = 1'b0;
    cyc();
    check("resume_fetch", 32'(FetchEn), 32'd1);
    check("resume_phase", 32'(Phase), 32'd0);

    // Asynchronous reset while waiting at address 17.
    imem[0] = OP_ADD;
    imem[17] = OP_HEI;
    iarg[17] = m_db;
    Sw8 = m_db;
    n = 0;
    while (!(m_addr == 17 && m_step == MW) && n < 200) begin
      cyc();
      n++;
    end
    repeat (3) cyc();
    check("addr17_waiting", 32'(Waiting), 32'd1);
    check("addr17_addr", 32'(InstrAddr), 32'd17);
    #2;
    nReset = 1'b0;
    model_reset();
    #1;
    check("arst_addr", 32'(InstrAddr), 32'd0);
    check("arst_phase", 32'(Phase), 32'd0);
    check("arst_waiting", 32'(Waiting), 32'd0);
    check("arst_fetchen", 32'(FetchEn), 32'd1);
    @(posedge Clock);
    #3;
    nReset = 1'b1;
    cyc();
    check("post_rst_phase", 32'(Phase), 32'd1);
    check("post_rst_regre", 32'(RegRe), 32'd1);

    // Randomized programs, switch activity and Hold.
    for (int i = 0; i <= LAST; i++) begin
      imem[i] = 6'($urandom);
      iarg[i] = 1'($urandom);
    end
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(7) == 0) Sw8 = ~Sw8;
      Hold = ($urandom_range(3) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
